// File: rtl/sample_clock_ctrl.sv
// Power-of-two sample clock divider plus break-before-make one-hot select for the glitch-free clock mux.
// All outputs registered; requests held off (cfg_ready=0) during a switch. SAMPLE_CLK_STOP_EN adds a stop code.
module sample_clock_ctrl #(
  parameter int NUM_CLOCKS = 4,
  parameter int RATE_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [RATE_W-1:0]     cfg_rate,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] div_clk,
  output logic [NUM_CLOCKS-1:0] clk_select,
  output logic [RATE_W-1:0]     cur_rate,
  output logic                  switching
);

  localparam int DW = NUM_CLOCKS + 3;
  localparam logic [RATE_W-1:0] STOP = RATE_W'(NUM_CLOCKS);

  typedef enum logic [1:0] {ACTIVE, DROP, ARM} state_t;

  state_t                  state, state_n;
  logic [DW-1:0]           drain, drain_n;
  logic [RATE_W-1:0]       new_rate, new_rate_n;
  logic [RATE_W-1:0]       cur_rate_n;
  logic [NUM_CLOCKS-1:0]   clk_select_n;
  logic                    cfg_err_n;
  logic                    accept;
  logic                    rate_ok;

  function automatic logic [NUM_CLOCKS-1:0] onehot(input logic [RATE_W-1:0] r);
    onehot = '0;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if (r == RATE_W'(i)) onehot[i] = 1'b1;
  endfunction

  // Drain is four periods of clock k, loaded as a terminal count (length - 1).
  function automatic logic [DW-1:0] drain_len(input logic [RATE_W-1:0] r);
    drain_len = '0;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if (r == RATE_W'(i)) drain_len = DW'((1 << (i + 3)) - 1);
  endfunction

  assign accept = cfg_valid & cfg_ready;

`ifdef SAMPLE_CLK_STOP_EN
  assign rate_ok = (cfg_rate < STOP) || (cfg_rate == STOP);
`else
  assign rate_ok = (cfg_rate < STOP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_clk <= '0;
    else     div_clk <= div_clk + NUM_CLOCKS'(1);
  end

  always_comb begin
    state_n      = state;
    drain_n      = drain;
    new_rate_n   = new_rate;
    cur_rate_n   = cur_rate;
    clk_select_n = clk_select;
    cfg_err_n    = 1'b0;
    case (state)
      ACTIVE: begin
        if (accept) begin
          if (!rate_ok) begin
            cfg_err_n = 1'b1;
          end else if (cfg_rate != cur_rate) begin
`ifdef SAMPLE_CLK_STOP_EN
            if (cur_rate == STOP) begin
              // Nothing is driving the mux, so there is nothing to drain.
              state_n      = ARM;
              clk_select_n = onehot(cfg_rate);
              cur_rate_n   = cfg_rate;
              drain_n      = drain_len(cfg_rate);
            end else
`endif
            begin
              state_n      = DROP;
              clk_select_n = '0;
              drain_n      = drain_len(cur_rate);
              new_rate_n   = cfg_rate;
            end
          end
        end
      end
      DROP: begin
        if (drain == '0) begin
          cur_rate_n   = new_rate;
          clk_select_n = onehot(new_rate);
`ifdef SAMPLE_CLK_STOP_EN
          if (new_rate == STOP) state_n = ACTIVE;
          else
`endif
          begin
            state_n = ARM;
            drain_n = drain_len(new_rate);
          end
        end else begin
          drain_n = drain - DW'(1);
        end
      end
      ARM: begin
        if (drain == '0) state_n = ACTIVE;
        else             drain_n = drain - DW'(1);
      end
      default: state_n = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACTIVE;
      drain      <= '0;
      new_rate   <= '0;
      cur_rate   <= '0;
      clk_select <= NUM_CLOCKS'(1);
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      switching  <= 1'b0;
    end else begin
      state      <= state_n;
      drain      <= drain_n;
      new_rate   <= new_rate_n;
      cur_rate   <= cur_rate_n;
      clk_select <= clk_select_n;
      cfg_err    <= cfg_err_n;
      cfg_ready  <= (state_n == ACTIVE);
      switching  <= (state_n != ACTIVE);
    end
  end

endmodule

// File: tb/tb_sample_clock_ctrl.sv
// Directed bench for sample_clock_ctrl: rate switching, no-op, error, hold-off, async reset, optional stop code.
module tb_sample_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_rate = 3'd0;
  logic       cfg_ready, cfg_err, switching;
  logic [3:0] div_clk, clk_select;
  logic [2:0] cur_rate;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit mon_en = 1'b0;
  int n;

  sample_clock_ctrl #(.NUM_CLOCKS(4), .RATE_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_rate(cfg_rate),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk),
    .clk_select(clk_select), .cur_rate(cur_rate), .switching(switching)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference cycle count since reset release; the divider must equal it mod 16.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("div_clk", {28'd0, div_clk}, cyc % 16);
      check("sel_onehot", {31'd0, ($countones(clk_select) <= 1)}, 32'd1);
    end
  end

  // Present a request; returns at the negedge following the accepting edge.
  task automatic req(input logic [2:0] r);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_rate  = r;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cnt);
    cnt = 0;
    while (switching && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and free-running divider.
    #12;
    check("rst_sel", {28'd0, clk_select}, 32'h1);
    check("rst_div", {28'd0, div_clk}, 32'h0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_sw", {31'd0, switching}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (64) @(negedge clk);
    check("idle_sel", {28'd0, clk_select}, 32'h1);
    check("idle_cur", {29'd0, cur_rate}, 32'd0);
    check("idle_ready", {31'd0, cfg_ready}, 32'd1);

    // 0 -> 3: 8 cycles dark, then 64 cycles armed.
    req(3'd3);
    check("sw_ready_lo", {31'd0, cfg_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("drop_sel", {28'd0, clk_select}, 32'h0);
      check("drop_sw", {31'd0, switching}, 32'd1);
      @(negedge clk);
    end
    check("arm_cur", {29'd0, cur_rate}, 32'd3);
    for (int i = 0; i < 64; i++) begin
      check("arm_sel", {28'd0, clk_select}, 32'h8);
      check("arm_sw", {31'd0, switching}, 32'd1);
      @(negedge clk);
    end
    check("done_sw", {31'd0, switching}, 32'd0);
    check("done_ready", {31'd0, cfg_ready}, 32'd1);
    check("done_cur", {29'd0, cur_rate}, 32'd3);

    // 3 -> 2 takes 64 + 32 cycles, then same-rate request is a no-op.
    req(3'd2);
    wait_idle(500, n);
    check("3to2_len", n, 32'd96);
    req(3'd2);
    check("noop_ready", {31'd0, cfg_ready}, 32'd1);
    check("noop_sw", {31'd0, switching}, 32'd0);
    check("noop_err", {31'd0, cfg_err}, 32'd0);
    check("noop_sel", {28'd0, clk_select}, 32'h4);
    @(negedge clk);
    check("noop_ready2", {31'd0, cfg_ready}, 32'd1);

    // Out-of-range request.
    req(3'd6);
    check("err_pulse", {31'd0, cfg_err}, 32'd1);
    check("err_cur", {29'd0, cur_rate}, 32'd2);
    check("err_sel", {28'd0, clk_select}, 32'h4);
    check("err_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    check("err_clear", {31'd0, cfg_err}, 32'd0);

    // Held request during 2 -> 0 switch is accepted only once idle.
    req(3'd0);
    cfg_valid = 1'b1;
    cfg_rate  = 3'd1;
    wait_idle(500, n);
    check("2to0_len", n, 32'd40);
    check("held_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("held_sw", {31'd0, switching}, 32'd1);
    check("held_sel", {28'd0, clk_select}, 32'h0);
    wait_idle(500, n);
    check("0to1_len", n, 32'd24);
    check("held_cur", {29'd0, cur_rate}, 32'd1);

    // Async reset in the middle of a DROP out of rate 3.
    req(3'd3);
    wait_idle(500, n);
    check("1to3_len", n, 32'd80);
    req(3'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", {28'd0, clk_select}, 32'h1);
    check("mid_rst_sw", {31'd0, switching}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("mid_rst_cur", {29'd0, cur_rate}, 32'd0);
    check("mid_rst_div", {28'd0, div_clk}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_sel", {28'd0, clk_select}, 32'h1);

`ifdef SAMPLE_CLK_STOP_EN
    req(3'd1);
    wait_idle(500, n);
    check("0to1b_len", n, 32'd24);
    req(3'd4);
    for (int i = 0; i < 16; i++) begin
      check("stop_sel", {28'd0, clk_select}, 32'h0);
      check("stop_sw", {31'd0, switching}, 32'd1);
      @(negedge clk);
    end
    check("stopped_sel", {28'd0, clk_select}, 32'h0);
    check("stopped_cur", {29'd0, cur_rate}, 32'd4);
    check("stopped_sw", {31'd0, switching}, 32'd0);
    check("stopped_ready", {31'd0, cfg_ready}, 32'd1);
    req(3'd4);
    check("restop_sw", {31'd0, switching}, 32'd0);
    check("restop_err", {31'd0, cfg_err}, 32'd0);
    req(3'd0);
    check("start_sel", {28'd0, clk_select}, 32'h1);
    check("start_cur", {29'd0, cur_rate}, 32'd0);
    check("start_sw", {31'd0, switching}, 32'd1);
    wait_idle(500, n);
    check("start_len", n, 32'd8);
    check("start_done_sel", {28'd0, clk_select}, 32'h1);
`else
    req(3'd4);
    check("stop_err", {31'd0, cfg_err}, 32'd1);
    check("stop_cur", {29'd0, cur_rate}, 32'd0);
    check("stop_sel", {28'd0, clk_select}, 32'h1);
    check("stop_sw", {31'd0, switching}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sample_clock_ctrl.md
# sample_clock_ctrl

Sample-rate controller that sits directly upstream of the glitch-free clock mux in the logic analyzer data path. It derives a set of power-of-two divided sample clocks from the system clock. It also drives the mux's one-hot select so that a rate change always follows a break-before-make sequence, with drain windows long enough for the mux's per-clock enable synchronisers to settle. Configuration arrives from the control register block over a valid/ready handshake.

## Interface
- NUM_CLOCKS, 4, number of divided clocks and mux select lines; 2..7.
- RATE_W, 3, width of rate index; must satisfy NUM_CLOCKS <= 2^RATE_W - 1.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cfg_valid  input  1  new rate request.
- cfg_rate  input  RATE_W  requested rate index k; clock k has period 2^(k+1) clk cycles.
- cfg_ready  output  1  controller can accept a request.
- cfg_err  output  1  one-cycle pulse when an out-of-range request is accepted.
- div_clk  output  NUM_CLOCKS  divided clocks to the mux clk inputs; bit k = counter bit k.
- clk_select  output  NUM_CLOCKS  one-hot (or all-zero) mux select.
- cur_rate  output  RATE_W  rate index currently selected.
- switching  output  1  high while a rate change is in progress.

## Operation
- Free-running NUM_CLOCKS-bit up counter, wraps 2^NUM_CLOCKS-1 -> 0. div_clk is the registered counter value, so div_clk[k] is a glitch-free square wave with period 2^(k+1).
- Drain length D(k) = 2^(k+3) clk cycles, which is 4 periods of clock k. Drain counter width is NUM_CLOCKS+3.
- FSM states:
  - ACTIVE: cfg_ready=1, switching=0, clk_select=onehot(cur_rate).
  - DROP: clk_select=0, wait D(old) cycles.
  - ARM: clk_select=onehot(new), cur_rate=new, wait D(new) cycles.
- Transitions:
  - ACTIVE with an accepted cfg_rate that is in range and differs from cur_rate -> DROP.
  - DROP with drain done -> ARM.
  - ARM with drain done -> ACTIVE.
- Accept = cfg_valid & cfg_ready. Requests are only accepted in ACTIVE; cfg_valid outside ACTIVE is held off, not dropped.
- Accepted cfg_rate equal to cur_rate: no-op. State stays ACTIVE, cfg_ready stays 1, no cfg_err.
- Accepted cfg_rate >= NUM_CLOCKS (except the stop code, see Configuration): ignored, cfg_err pulses for 1 cycle, state unchanged.
- The divider counter runs uninterrupted through every state. A rate change never resets div_clk.
- Reset values: counter 0, div_clk 0, state ACTIVE, cur_rate 0, clk_select = 1 (bit 0), cfg_ready 1, cfg_err 0, switching 0.
- Reset asserted mid-switch returns all outputs to their reset values immediately (async). The ACTIVE state is entered on the first clk edge after reset deassertion.

## Timing
- A request accepted on edge N produces, after edge N: clk_select=0, switching=1, cfg_ready=0.
- The new one-hot appears after edge N+D(old). cur_rate updates on the same edge.
- After edge N+D(old)+D(new): ACTIVE, switching=0, cfg_ready=1. The earliest next acceptance is on that edge+1.
- At no edge does clk_select have more than one bit set.
- cfg_err asserts in the cycle after the accepting edge, for exactly one cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SAMPLE_CLK_STOP_EN defined:
  - cfg_rate == NUM_CLOCKS is a legal stop code. It goes through DROP with D(old), then returns to ACTIVE with clk_select=0 and cur_rate=NUM_CLOCKS, and skips ARM.
  - From the stopped state, a valid rate skips DROP (zero drain) and enters ARM directly.
  - Requesting the stop code while already stopped is a no-op.
- SAMPLE_CLK_STOP_EN undefined: cfg_rate == NUM_CLOCKS is out of range and gives a cfg_err pulse. clk_select is never all-zero outside DROP.

## Test plan
- Reset then release, run 64 cycles -> clk_select=4'b0001, cur_rate=0, cfg_ready=1; div_clk[0] toggles every cycle and div_clk[3] has a period of 16 cycles.
- From rate 0, request rate 3 -> clk_select=0 for exactly 8 cycles, then 4'b1000 for 64 cycles; switching is high for 72 cycles, then cfg_ready=1 and cur_rate=3.
- Request rate 2 while cur_rate=2 -> no state change, clk_select unchanged, cfg_ready never drops, cfg_err=0.
- Request rate 6 with NUM_CLOCKS=4 -> cfg_err is a single-cycle pulse, cur_rate and clk_select are unchanged; cfg_valid held high during a switch is accepted only after switching falls.
- Assert rst mid-DROP from rate 3 -> clk_select=4'b0001, switching=0, cfg_ready=1 in the same cycle; a checker confirms popcount(clk_select) <= 1 on every edge of every test.
- With SAMPLE_CLK_STOP_EN, stop from rate 1 (cfg_rate=4), then request rate 0 -> clk_select=0 after 16 drain cycles and cur_rate=4; then ARM immediately with 4'b0001 for 8 cycles and return to ACTIVE.
